fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin burst arbiter that shares the single write port of one `fifo` instance between N_REQ producers.
- Each producer presents data through a valid/ready handshake.
- The arbiter grants one producer at a time for a burst of up to BURST_MAX beats and drives `write`/`data_in` of the downstream FIFO.
- Sits directly in front of the FIFO write side; the read side is untouched.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- WIDTH, 8, data width; matches FIFO WIDTH.
- BURST_MAX, 4, maximum beats per grant (1..256).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  N_REQ  per-requester data valid.
- req_data  in  N_REQ*WIDTH  packed data; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  N_REQ  per-requester accept; a beat transfers when valid&ready.
- fifo_full  in  1  full flag from FIFO.
- fifo_write  out  1  write strobe to FIFO.
- fifo_data_in  out  WIDTH  data to FIFO.
- grant  out  N_REQ  one-hot current owner; 0 when idle.
- busy  out  1  high in BURST state.

Behaviour:
- Reset: synchronous and active-high, as already decided. On the rst edge:
  - state=IDLE, rr_ptr=0, grant=0, beat_cnt=0.
  - While rst is high, req_ready=0, fifo_write=0, fifo_data_in=0, busy=0.
- FSM states: IDLE, BURST.
- IDLE:
  - If any req_valid is set, pick the first set bit searching circularly from rr_ptr upward (wrap N_REQ-1 -> 0).
  - Register the winner in grant, clear beat_cnt, go to BURST.
  - No transfer happens in IDLE: one-cycle arbitration bubble.
  - If no requester is valid, stay in IDLE.
- BURST, with g = granted index:
  - req_ready[g] = !fifo_full. All other req_ready bits are 0.
  - fifo_write = req_valid[g] & !fifo_full (combinational).
  - fifo_data_in = req_data[g] (mux, combinational). Its value is 0 in IDLE.
  - On a transfer, beat_cnt increments.
- BURST exit: go to IDLE, clear grant, set rr_ptr=(g+1) mod N_REQ when either:
  - a transfer occurs with beat_cnt==BURST_MAX-1; or
  - req_valid[g]==0 in any BURST cycle (requester ended its burst early; no transfer that cycle).
- fifo_full during BURST: no transfer, beat_cnt holds, grant held. No timeout.
- fifo_full and req_valid[g]==0 together: the exit rule applies.
- Exactly one write per cycle max. Never write while fifo_full=1.
- Latency: the first beat is written 1 cycle after valid rises in IDLE. A burst of B beats with no stalls occupies B+1 cycles including the bubble.
- Fairness: after a maximal burst, every other valid requester is served before g again.
- beat_cnt width is $clog2(BURST_MAX)+1. BURST_MAX=1 degenerates to single-beat round-robin.
- rr_ptr width is $clog2(N_REQ). Wrap is explicit, not power-of-two dependent.
- Reset mid-burst: the burst is abandoned; no write in the reset cycle; the next arbitration starts from requester 0.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- Defined:
  - Adds output xfer_cnt (N_REQ*16): per-requester 16-bit counters that increment on each accepted beat.
  - Counters saturate at 16'hFFFF and clear on rst.
- Undefined:
  - Port and counters are absent.
  - All other behaviour is identical.

Decomposition:
- Package fifo_arb_pkg:
  - typedef enum logic {IDLE, BURST} arb_state_t.
  - Function rr_pick(valid, ptr), returning the index.
  - Localparam STAT_W=16.
- Sub-module rr_picker: combinational circular priority encoder (valid vector + pointer -> index + found). Reusable by a future read-side scheduler.
- FSM, counters and muxing stay in fifo_wr_arbiter.

Test Plan:
- Single requester:
  - Stimulus: rst, then req_valid=4'b0100 held, data 0x10..0x17, fifo_full=0, BURST_MAX=4.
  - Expected: grant=0100 after 1 cycle; writes 0x10..0x13 on 4 consecutive cycles; 1 idle cycle; re-grant to requester 2; writes 0x14..0x17.
- All four requesters valid continuously:
  - Expected: grant order 0,1,2,3,0; each burst exactly 4 writes; 20 writes in 25 cycles.
- Early release:
  - Stimulus: requester 1 valid for 2 beats then drops.
  - Expected: 2 writes, IDLE the next cycle, rr_ptr=2; valid requester 3 is granted next.
- Backpressure:
  - Stimulus: fifo_full=1 for 3 cycles mid-burst after beat 2.
  - Expected: fifo_write=0 and req_ready=0 for those cycles; beat_cnt holds at 2; beats 3 and 4 complete after full drops; total 4 writes.
- Reset mid-burst:
  - Stimulus: assert rst after beat 1 of requester 3's grant.
  - Expected: that cycle fifo_write=0 and grant=0; next arbitration with all valid picks requester 0.
- With FIFO_ARB_STATS_EN:
  - Stimulus: 70000 beats from requester 0.
  - Expected: xfer_cnt[0]=16'hFFFF; others 0; rst clears all counters.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
// Common to both builds; FIFO_ARB_STATS_EN only affects fifo_wr_arbiter.
package fifo_arb_pkg;

    typedef enum logic {IDLE, BURST} arb_state_t;

    localparam int STAT_W    = 16;
    localparam int MAX_REQ   = 16;
    localparam int MAX_IDX_W = 4;

    // First set bit of valid[0 +: n_req], searching circularly upward from ptr.
    function automatic logic [MAX_IDX_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0]   valid,
        input logic [MAX_IDX_W-1:0] ptr,
        input int                   n_req
    );
        logic [MAX_IDX_W-1:0] idx;
        logic                 hit;
        int                   c;
        idx = ptr;
        hit = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            c = int'(ptr) + k;
            if (c >= n_req) c = c - n_req;
            if (!hit && (k < n_req) && valid[c[MAX_IDX_W-1:0]]) begin
                hit = 1'b1;
                idx = c[MAX_IDX_W-1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational circular priority encoder: valid vector + start pointer -> winner index.
// Common to both builds; FIFO_ARB_STATS_EN only affects fifo_wr_arbiter.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    logic [MAX_REQ-1:0]   w_valid_ext;
    logic [MAX_IDX_W-1:0] w_ptr_ext;
    logic [MAX_IDX_W-1:0] w_pick;

    assign w_valid_ext = MAX_REQ'(i_valid);
    assign w_ptr_ext   = MAX_IDX_W'(i_ptr);
    assign w_pick      = rr_pick(w_valid_ext, w_ptr_ext, N_REQ);
    assign o_idx       = w_pick[IDX_W-1:0];
    assign o_found     = |i_valid;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between N_REQ producers.
// Define FIFO_ARB_STATS_EN to add saturating per-requester beat counters (xfer_cnt).
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_write,
    output logic [WIDTH-1:0]         fifo_data_in,
    output logic [N_REQ-1:0]         grant,
    output logic                     busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [N_REQ*STAT_W-1:0]  xfer_cnt
`endif
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int BEAT_W = $clog2(BURST_MAX) + 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_REQ - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_MAX - 1);

    arb_state_t        r_state;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [IDX_W-1:0]  r_gidx;
    logic [BEAT_W-1:0] r_beat_cnt;

    arb_state_t        w_state_nxt;
    logic [IDX_W-1:0]  w_rr_ptr_nxt;
    logic [IDX_W-1:0]  w_gidx_nxt;
    logic [BEAT_W-1:0] w_beat_cnt_nxt;

    logic [IDX_W-1:0]  w_pick_idx;
    logic              w_pick_found;
    logic              w_valid_g;
    logic [WIDTH-1:0]  w_data_g;
    logic              w_active;
    logic              w_xfer;
    logic [IDX_W-1:0]  w_ptr_after;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_valid (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        w_valid_g = 1'b0;
        w_data_g  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_gidx == IDX_W'(i)) begin
                w_valid_g = req_valid[i];
                w_data_g  = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Outputs are forced quiet while rst is high, even before the reset edge lands.
    assign w_active    = (r_state == BURST) && !rst;
    assign w_xfer      = w_active && w_valid_g && !fifo_full;
    assign w_ptr_after = (r_gidx == LAST_IDX) ? '0 : r_gidx + 1'b1;

    always_comb begin
        req_ready    = '0;
        grant        = '0;
        fifo_write   = 1'b0;
        fifo_data_in = '0;
        busy         = 1'b0;
        if (w_active) begin
            busy              = 1'b1;
            grant[r_gidx]     = 1'b1;
            req_ready[r_gidx] = !fifo_full;
            fifo_write        = w_xfer;
            fifo_data_in      = w_data_g;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_gidx_nxt     = r_gidx;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt    = BURST;
                    w_gidx_nxt     = w_pick_idx;
                    w_beat_cnt_nxt = '0;
                end
            end
            BURST: begin
                if (!w_valid_g) begin
                    w_state_nxt  = IDLE;
                    w_rr_ptr_nxt = w_ptr_after;
                end else if (!fifo_full) begin
                    if (r_beat_cnt == LAST_BEAT) begin
                        w_state_nxt  = IDLE;
                        w_rr_ptr_nxt = w_ptr_after;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_gidx     <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_gidx     <= w_gidx_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    for (genvar i = 0; i < N_REQ; i++) begin : g_stat
        logic [STAT_W-1:0] r_cnt;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (w_xfer && (r_gidx == IDX_W'(i)) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
        assign xfer_cnt[i*STAT_W +: STAT_W] = r_cnt;
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random traffic vs a cycle model.
// Define FIFO_ARB_STATS_EN to also check the xfer_cnt counters.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int BM = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_full;
    logic           fifo_write;
    logic [W-1:0]   fifo_data_in;
    logic [N-1:0]   grant;
    logic           busy;
`ifdef FIFO_ARB_STATS_EN
    logic [N*16-1:0] xfer_cnt;
`endif

    fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .BURST_MAX(BM)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_write   (fifo_write),
        .fifo_data_in (fifo_data_in),
        .grant        (grant),
        .busy         (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .xfer_cnt     (xfer_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: who owns the port, how many beats taken, where the next search starts.
    int m_owner = -1;
    int m_beats = 0;
    int m_ptr   = 0;
    int m_cnt[N];

    // Logs taken from DUT outputs for the directed scenarios.
    int           n_wr;
    int           wr_by[N];
    logic [W-1:0] wlog[$];
    int           gq[$];
    logic [N-1:0] last_grant;

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic set_data(input int idx, input logic [W-1:0] val);
        req_data[idx*W +: W] = val;
    endtask

    task automatic step();
        logic [N-1:0] e_grant, e_ready;
        logic         e_write, e_busy;
        logic [W-1:0] e_data;
        int           g, idx;
        @(negedge clk);
        e_grant = '0; e_ready = '0; e_write = 1'b0; e_busy = 1'b0; e_data = '0;
        if (!rst && m_owner >= 0) begin
            e_busy           = 1'b1;
            e_grant          = N'(1) << m_owner;
            e_ready[m_owner] = !fifo_full;
            e_write          = req_valid[m_owner] && !fifo_full;
            e_data           = req_data[m_owner*W +: W];
        end
        check("grant",     64'(grant),        64'(e_grant));
        check("req_ready", 64'(req_ready),    64'(e_ready));
        check("write",     64'(fifo_write),   64'(e_write));
        check("data_in",   64'(fifo_data_in), 64'(e_data));
        check("busy",      64'(busy),         64'(e_busy));
`ifdef FIFO_ARB_STATS_EN
        for (int i = 0; i < N; i++) check("xfer_cnt", 64'(xfer_cnt[i*16 +: 16]), 64'(m_cnt[i]));
`endif
        if (fifo_write) begin
            n_wr++;
            wlog.push_back(fifo_data_in);
            g = onehot_idx(grant);
            if (g >= 0) wr_by[g]++;
        end
        if (grant != '0 && last_grant == '0) gq.push_back(onehot_idx(grant));
        last_grant = grant;

        if (rst) begin
            m_owner = -1; m_ptr = 0; m_beats = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (req_valid[idx]) begin
                    m_owner = idx;
                    m_beats = 0;
                    break;
                end
            end
        end else if (!req_valid[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else if (!fifo_full) begin
            m_beats++;
            if (m_cnt[m_owner] < 65535) m_cnt[m_owner]++;
            if (m_beats == BM) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        n_wr = 0;
        wlog.delete();
        gq.delete();
        for (int i = 0; i < N; i++) wr_by[i] = 0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        fifo_full = 1'b0;
        step();
        step();
        rst = 1'b0;
        clear_logs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        bit hit;
        rst        = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        fifo_full  = 1'b0;
        last_grant = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        clear_logs();
        @(posedge clk);
        #1;

        // Single requester: two back-to-back maximal bursts from requester 2.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            req_valid = (n_wr < 8) ? 4'b0100 : 4'b0000;
            set_data(2, W'(8'h10 + n_wr));
            step();
        end
        check("single_writes", 64'(n_wr), 64'd8);
        for (int i = 0; i < 8; i++) check("single_data", 64'(wlog[i]), 64'(8'h10 + i));
        check("single_grants", 64'(gq.size()), 64'd2);
        check("single_gnt0", 64'(gq[0]), 64'd2);
        check("single_gnt1", 64'(gq[1]), 64'd2);

        // All four requesters valid: round-robin order, 20 writes in 25 cycles.
        do_reset();
        req_valid = 4'b1111;
        for (int c = 0; c < 25; c++) begin
            for (int i = 0; i < N; i++) set_data(i, W'($urandom()));
            step();
        end
        check("all_writes", 64'(n_wr), 64'd20);
        check("all_grants", 64'(gq.size()), 64'd5);
        for (int i = 0; i < 5; i++) check("all_order", 64'(gq[i]), 64'(i % N));
        for (int i = 0; i < N; i++) check("all_per_req", 64'(wr_by[i]), (i == 0) ? 64'd8 : 64'd4);

        // Early release by requester 1; requester 3 must be served next.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            req_valid = {1'b1, 1'b0, (wr_by[1] < 2), 1'b0};
            for (int i = 0; i < N; i++) set_data(i, W'($urandom()));
            step();
        end
        check("early_req1_writes", 64'(wr_by[1]), 64'd2);
        check("early_first", 64'(gq[0]), 64'd1);
        check("early_next", 64'(gq[1]), 64'd3);
        check("early_req3_writes", 64'(wr_by[3]), 64'd4);

        // Backpressure: FIFO full for 3 cycles after beat 2.
        do_reset();
        stalls = 0;
        for (int c = 0; c < 12; c++) begin
            req_valid = {3'b000, (n_wr < 4)};
            fifo_full = (n_wr == 2) && (stalls < 3);
            if (fifo_full) stalls++;
            set_data(0, W'($urandom()));
            step();
        end
        fifo_full = 1'b0;
        check("bp_writes", 64'(n_wr), 64'd4);
        check("bp_grants", 64'(gq.size()), 64'd1);

        // Reset after beat 1 of requester 3's grant.
        do_reset();
        req_valid = 4'b1111;
        hit = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (wr_by[3] == 1) begin
                hit = 1'b1;
                break;
            end
        end
        check("rst_reach_req3", 64'(hit), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("rst_regrant", 64'(grant), 64'(4'b0001));

        // Random traffic with occasional resets and backpressure.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++) begin
                req_valid[i] = ($urandom_range(0, 9) < 7);
                set_data(i, W'($urandom()));
            end
            fifo_full = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
